// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage-register chain.
//   - Stage index names for the classic 4-deep core pipeline.
//   - Performance counter width.
//   - Stage record type ({valid, payload}) at the core's default width.
//   - sat_add(): saturating counter increment used by the perf counters.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;

    localparam int PERF_CNT_W = 16;
    localparam int DEF_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic [DEF_DATA_W-1:0] payload;
    } stage_rec_t;

    // Add a small per-cycle increment to a counter, clamping at all-ones.
    function automatic logic [PERF_CNT_W-1:0] sat_add(
        input logic [PERF_CNT_W-1:0] cnt,
        input logic [3:0]            inc
    );
        logic [PERF_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(PERF_CNT_W-3){1'b0}}, inc};
        if (sum[PERF_CNT_W]) begin
            return {PERF_CNT_W{1'b1}};
        end else begin
            return sum[PERF_CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// One pipeline boundary register carrying {valid, payload}.
// Next-state priority: flush > hold > bubble > load from upstream.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (clears valid and payload)
//   up_valid  in   valid bit of the upstream record
//   up_data   in   payload of the upstream record
//   hold      in   keep the current contents
//   bubble    in   upstream is frozen: load an empty slot
//   flush     in   invalidate this stage (beats hold)
//   q_valid   out  registered valid bit
//   q_data    out  registered payload
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic              hold,
    input  logic              bubble,
    input  logic              flush,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next-state selection in priority order.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush || (bubble && !hold)) begin
            // Empty slot: payload either cleared or left as it was.
            valid_d = 1'b0;
            if (ZERO_BUBBLE) begin
                data_d = {DATA_W{1'b0}};
            end else begin
                data_d = data_q;
            end
        end else if (hold) begin
            valid_d = valid_q;
            data_d  = data_q;
        end else begin
            valid_d = up_valid;
            data_d  = up_data;
        end
    end

    // Stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= {DATA_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign q_valid = valid_q;
    assign q_data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
// Chain of NUM_STAGES pipeline boundary registers (index 0 = IF/ID, youngest;
// NUM_STAGES-1 = MEM/WB, oldest) with backward stall propagation, per-stage
// flush and automatic bubble insertion.
//
// Optional build macro: PIPE_PERF_CNT_EN
//   defined   -> saturating 16-bit bubble and flush counters are built
//   undefined -> bubble_cnt / flush_cnt are tied to zero (same port list)
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   in_valid     in   fetch presents a valid record
//   in_data      in   fetch payload
//   in_ready     out  stage 0 accepts in_data this cycle (combinational)
//   stall_req    in   bit i: consumer of stage i cannot advance
//   flush        in   bit i: invalidate stage i this cycle
//   stage_valid  out  valid bit of each stage register
//   stage_data   out  payload of stage i at [i*DATA_W +: DATA_W]
//   bubble_cnt   out  bubbles inserted
//   flush_cnt    out  valid entries killed by flush
// -----------------------------------------------------------------------------
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int DATA_W      = 64,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    input  logic [NUM_STAGES-1:0]        stall_req,
    input  logic [NUM_STAGES-1:0]        flush,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*DATA_W-1:0] stage_data,
    output logic [PERF_CNT_W-1:0]        bubble_cnt,
    output logic [PERF_CNT_W-1:0]        flush_cnt
);

    logic [NUM_STAGES-1:0] hold_s;
    logic [NUM_STAGES-1:0] bubble_s;

    // A stall anywhere downstream freezes stage i, so hold is the OR of
    // stall_req from i up to the oldest stage. A bubble appears exactly where
    // the frozen region ends: upstream held, this stage free.
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_ctl
        assign hold_s[i] = |stall_req[NUM_STAGES-1:i];
        if (i == 0) begin : g_first
            assign bubble_s[i] = 1'b0;
        end else begin : g_rest
            assign bubble_s[i] = hold_s[i-1] & ~hold_s[i];
        end
    end

    assign in_ready = ~hold_s[STG_IF_ID];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic              up_valid_s;
        logic [DATA_W-1:0] up_data_s;

        if (i == 0) begin : g_src_in
            assign up_valid_s = in_valid;
            assign up_data_s  = in_data;
        end else begin : g_src_prev
            assign up_valid_s = stage_valid[i-1];
            assign up_data_s  = stage_data[(i-1)*DATA_W +: DATA_W];
        end

        pipe_stage_reg #(
            .DATA_W      (DATA_W),
            .ZERO_BUBBLE (ZERO_BUBBLE)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (up_valid_s),
            .up_data  (up_data_s),
            .hold     (hold_s[i]),
            .bubble   (bubble_s[i]),
            .flush    (flush[i]),
            .q_valid  (stage_valid[i]),
            .q_data   (stage_data[i*DATA_W +: DATA_W])
        );
    end

`ifdef PIPE_PERF_CNT_EN
    logic [3:0]            bub_inc_s;
    logic [3:0]            fl_inc_s;
    logic [PERF_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    // Per-cycle event counts: bubbles only where flush does not take priority;
    // flushes only where a valid entry is actually killed.
    always_comb begin
        bub_inc_s = 4'd0;
        fl_inc_s  = 4'd0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            bub_inc_s = bub_inc_s + {3'd0, bubble_s[i] & ~flush[i]};
            fl_inc_s  = fl_inc_s  + {3'd0, flush[i] & stage_valid[i]};
        end
        bubble_cnt_d = sat_add(bubble_cnt_q, bub_inc_s);
        flush_cnt_d  = sat_add(flush_cnt_q,  fl_inc_s);
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= {PERF_CNT_W{1'b0}};
            flush_cnt_q  <= {PERF_CNT_W{1'b0}};
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign bubble_cnt = 16'h0000;
    assign flush_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
// Directed checks of the 4-stage, 64-bit, zero-bubble configuration.
// Counter expectations follow whether PIPE_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         in_ready;
    logic [3:0]   stall_req;
    logic [3:0]   flush;
    logic [3:0]   stage_valid;
    logic [255:0] stage_data;
    logic [15:0]  bubble_cnt;
    logic [15:0]  flush_cnt;

    int n_total;
    int n_pass;

    pipe_stage_chain #(
        .NUM_STAGES  (4),
        .DATA_W      (64),
        .ZERO_BUBBLE (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall_req   (stall_req),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .bubble_cnt  (bubble_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] pack4(input logic [63:0] d3, input logic [63:0] d2,
                                           input logic [63:0] d1, input logic [63:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Expected counter value depends on whether counters are built.
    function automatic logic [15:0] expc(input logic [15:0] v);
`ifdef PIPE_PERF_CNT_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic load4(input logic [63:0] d3, input logic [63:0] d2,
                         input logic [63:0] d1, input logic [63:0] d0);
        in_valid = 1'b1;
        in_data = d3; tick();
        in_data = d2; tick();
        in_data = d1; tick();
        in_data = d0; tick();
        in_valid = 1'b0;
        in_data  = 64'd0;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        stall_req = 4'b0000;
        flush     = 4'b0000;
        tick();
        tick();

        // Reset state
        chk("rst_valid", stage_valid, 256'd0);
        chk("rst_data",  stage_data,  256'd0);
        chk("rst_bub",   bubble_cnt,  256'd0);
        chk("rst_fl",    flush_cnt,   256'd0);
        chk("rst_rdy",   in_ready,    256'd1);
        reset = 1'b0;

        // Streaming 1..5 with no stalls
        for (int k = 1; k <= 5; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(k);
            #1;
            chk("stream_rdy", in_ready, 256'd1);
            tick();
            chk("stream_s0", stage_data[63:0], 256'(k));
            if (k == 4) begin
                chk("stream_s3_first", stage_data[255:192], 256'd1);
                chk("stream_full_v", stage_valid, 256'hF);
            end else begin
                chk("stream_s0_v", stage_valid[0], 256'd1);
            end
        end
        chk("stream_data", stage_data, pack4(64'd2, 64'd3, 64'd4, 64'd5));
        in_valid = 1'b0;
        in_data  = 64'd0;
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk("stream_s3", stage_data[255:192], 256'(k));
            chk("stream_s3_v", stage_valid[3], 256'd1);
        end
        tick();
        chk("drain_valid", stage_valid, 256'd0);

        // Load-use stall: stage0=A0, stage1=B0
        in_valid = 1'b1;
        in_data = 64'hB0; tick();
        in_data = 64'hA0; tick();
        stall_req = 4'b0001;
        in_data   = 64'hC0;
        #1;
        chk("lu_rdy", in_ready, 256'd0);
        tick();
        chk("lu_valid", stage_valid, 256'b0101);
        chk("lu_data",  stage_data, pack4(64'd0, 64'hB0, 64'd0, 64'hA0));
        chk("lu_bub",   bubble_cnt, expc(16'd1));
        chk("lu_fl",    flush_cnt,  expc(16'd0));
        stall_req = 4'b0000;
        in_valid  = 1'b0;
        in_data   = 64'd0;

        // Branch flush of stages 0..1
        load4(64'h13, 64'h12, 64'h11, 64'h10);
        chk("br_pre_valid", stage_valid, 256'hF);
        chk("br_pre_data",  stage_data, pack4(64'h13, 64'h12, 64'h11, 64'h10));
        flush = 4'b0011;
        tick();
        flush = 4'b0000;
        chk("br_valid", stage_valid, 256'b1100);
        chk("br_data",  stage_data, pack4(64'h12, 64'h11, 64'd0, 64'd0));
        chk("br_fl",    flush_cnt,  expc(16'd2));
        chk("br_bub",   bubble_cnt, expc(16'd1));

        // Flush of stage 0 while stage 2 stalls
        load4(64'h23, 64'h22, 64'h21, 64'h20);
        stall_req = 4'b0100;
        flush     = 4'b0001;
        #1;
        chk("fh_rdy", in_ready, 256'd0);
        tick();
        stall_req = 4'b0000;
        flush     = 4'b0000;
        chk("fh_valid", stage_valid, 256'b0110);
        chk("fh_data",  stage_data, pack4(64'd0, 64'h22, 64'h21, 64'd0));
        chk("fh_fl",    flush_cnt,  expc(16'd3));
        chk("fh_bub",   bubble_cnt, expc(16'd2));

        // Oldest-stage stall freezes the whole chain; its flush still applies
        load4(64'h33, 64'h32, 64'h31, 64'h30);
        stall_req = 4'b1000;
        in_valid  = 1'b1;
        in_data   = 64'h99;
        tick();
        chk("old_hold_v", stage_valid, 256'hF);
        chk("old_hold_d", stage_data, pack4(64'h33, 64'h32, 64'h31, 64'h30));
        chk("old_hold_bub", bubble_cnt, expc(16'd2));
        flush = 4'b1000;
        tick();
        flush = 4'b0000;
        chk("old_fl_v", stage_valid, 256'b0111);
        chk("old_fl_d", stage_data, pack4(64'd0, 64'h32, 64'h31, 64'h30));
        chk("old_fl_cnt", flush_cnt, expc(16'd4));

        // Reset mid-operation with everything stalled
        stall_req = 4'b0000;
        tick();
        chk("mid_full_v", stage_valid, 256'hF);
        stall_req = 4'b1111;
        #1;
        chk("mid_rdy_pre", in_ready, 256'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_v",   stage_valid, 256'd0);
        chk("mid_rst_d",   stage_data,  256'd0);
        chk("mid_rst_bub", bubble_cnt,  256'd0);
        chk("mid_rst_fl",  flush_cnt,   256'd0);
        chk("mid_rst_rdy", in_ready,    256'd0);
        tick();
        chk("mid_held_v", stage_valid, 256'd0);
        stall_req = 4'b0000;
        in_valid  = 1'b0;
        in_data   = 64'd0;

        // Counter saturation under a permanent stage-0 stall
        stall_req = 4'b0001;
`ifdef PIPE_PERF_CNT_EN
        repeat (70000) tick();
        chk("sat_bub", bubble_cnt, 256'hFFFF);
        repeat (5) tick();
        chk("sat_bub_stay", bubble_cnt, 256'hFFFF);
        chk("sat_fl", flush_cnt, 256'd0);
`else
        repeat (50) tick();
        chk("nocnt_bub", bubble_cnt, 256'd0);
        chk("nocnt_fl",  flush_cnt,  256'd0);
`endif
        chk("sat_s1_bubble", stage_valid, 256'd0);
        stall_req = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised replacement for the per-boundary pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Implements NUM_STAGES stage registers carrying a DATA_W payload plus a valid bit.
- Handles per-stage stall requests with backward hold propagation, per-stage flush, and automatic bubble insertion.
- Sits between the pipeline stage logic in the core top level. Control and data fields are packed into the payload by the instantiating level.

Parameters:
- NUM_STAGES, 4, number of stage registers; index 0 is the youngest (IF/ID), NUM_STAGES-1 is the oldest (MEM/WB); legal range 2..8.
- DATA_W, 64, payload width per stage.
- ZERO_BUBBLE, 1, 1: payload forced to 0 when a bubble or flush is loaded; 0: payload register keeps its old value.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, fetch presents a valid instruction record.
- in_data, input, DATA_W, fetch payload.
- in_ready, output, 1, stage 0 accepts in_data this cycle.
- stall_req, input, NUM_STAGES, bit i: stage i's consumer cannot advance (e.g. hazard unit sets bit 0 for a load-use stall).
- flush, input, NUM_STAGES, bit i: invalidate stage i this cycle (branch taken sets bits 0..1).
- stage_valid, output, NUM_STAGES, valid bit of each stage register.
- stage_data, output, NUM_STAGES*DATA_W, payload of stage i at bits [i*DATA_W +: DATA_W].
- bubble_cnt, output, 16, bubbles inserted (see Optional Feature).
- flush_cnt, output, 16, valid entries killed by flush (see Optional Feature).

Behaviour:
- Reset:
  - When reset=1 at a rising edge, all stage_valid=0 and all stage_data=0.
  - bubble_cnt=0, flush_cnt=0.
  - Reset overrides stall_req and flush on the same edge.
  - Reset asserted mid-stream discards all contents; no partial retention.
- Hold:
  - hold[i] = OR of stall_req[NUM_STAGES-1:i]. A stall at stage j freezes stage j and every younger stage.
  - in_ready = !hold[0]. This is a combinational output.
- Per-stage next state, evaluated in priority order each edge:
  1. flush[i]=1: valid<=0; data<=0 if ZERO_BUBBLE else held. Flush beats hold.
  2. hold[i]=1: valid and data unchanged.
  3. i>0 and hold[i-1]=1 (upstream frozen, this stage free): bubble. valid<=0; data<=0 if ZERO_BUBBLE else held.
  4. Otherwise load the upstream value: stage 0 <= {in_valid, in_data}; stage i <= stage i-1.
- Timing:
  - Latency from stage i-1 to stage i is one cycle.
  - A record entering stage 0 appears at stage NUM_STAGES-1 after NUM_STAGES-1 further unstalled cycles.
- Oldest stage: the oldest stage's output is consumed unconditionally by write-back. Its stall_req bit only freezes the chain.
- Flush and stall together: stage i flushed while downstream still held → stage i goes invalid, and the hold is preserved for the stages that are not flushed.
- in_valid=0 with no hold: stage 0 loads valid=0. This does not count as a bubble.
- No combinational path from stall_req or flush to stage_valid or stage_data. The only combinational paths are stall_req → in_ready.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- With the macro defined:
  - bubble_cnt increments by the number of stages taking rule 3 in the cycle.
  - flush_cnt increments by the number of stages with flush[i]=1 and stage_valid[i]=1.
  - Both counters are 16-bit and saturate at 16'hFFFF.
  - Both clear on reset.
- Without the macro: counter registers are not built; bubble_cnt and flush_cnt are tied to 16'h0000. Port list is identical in both builds.

Decomposition:
- Shared package pipe_pkg holds:
  - stage index localparams STG_IF_ID=0, STG_ID_EX=1, STG_EX_MEM=2, STG_MEM_WB=3;
  - PERF_CNT_W=16;
  - typedef for the stage record {valid, payload}.
- One sub-module, pipe_stage_reg: a single stage with inputs up_valid, up_data, hold, bubble, flush.
- The chain instantiates NUM_STAGES copies of pipe_stage_reg in a generate loop, plus the hold OR-reduction and the counters.

Test Plan:
- Streaming: reset, then in_valid=1 with in_data=1,2,3,4,5 on consecutive cycles, no stalls → stage 3 shows data=1 valid=1 at cycle 4 after the first load, then 2,3,4,5 in order; in_ready stays 1.
- Load-use stall: stage0=A, stage1=B; assert stall_req=4'b0001 for 1 cycle → stage0 holds A, stage1 becomes a bubble (valid=0, data=0), stage2=B; in_ready=0 that cycle; bubble_cnt=1.
- Branch flush: stages hold 0x10,0x11,0x12,0x13 all valid; flush=4'b0011 → next edge stage0/stage1 valid=0, stage2=0x11, stage3=0x12; flush_cnt=2.
- Flush vs hold: stall_req=4'b0100 and flush=4'b0001 on the same cycle → stage0 valid=0, stage1/stage2 unchanged, stage3 becomes a bubble.
- Reset mid-operation: all stages valid and stall_req=4'b1111; assert reset for 1 cycle → all stage_valid=0, all stage_data=0, counters=0; in_ready=0 while stall_req is held.
- Saturation (macro defined): force 70000 bubble cycles → bubble_cnt=16'hFFFF and stays there. Without the macro, both counters read 0 throughout.
